// File: rtl/tick_gen.sv
// Multi-channel programmable clock-enable / square-wave generator.
// Each channel emits a one-cycle tick and toggles its level every div+1 enabled cycles.
module tick_gen #(
  parameter int                        NUM_CH   = 3,
  parameter int                        CNT_W    = 32,
  parameter logic [NUM_CH*CNT_W-1:0]   INIT_DIV = {32'd30000000, 32'd20000, 32'd50000000}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic                      sync,
  input  logic                      wr_en,
  input  logic [3:0]                wr_ch,
  input  logic [CNT_W-1:0]          wr_div,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         level,
  output logic [NUM_CH*CNT_W-1:0]   rd_div
);

  localparam logic [4:0] NUM_CH_W = 5'(NUM_CH);

  logic [CNT_W-1:0]  div_q [NUM_CH];
  logic [CNT_W-1:0]  div_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] level_q, level_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] wr_hit;
  logic              wr_valid;

  always_comb begin
    wr_valid = wr_en && ({1'b0, wr_ch} < NUM_CH_W);
    wr_hit   = '0;
    level_d  = level_q;
    tick_d   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      div_d[i]  = div_q[i];
      cnt_d[i]  = cnt_q[i];
      wr_hit[i] = wr_valid && (wr_ch == 4'(i));
      if (wr_hit[i]) begin
        div_d[i] = wr_div;
      end
      // Sync wins over the write for counter/level, but the divisor update above still lands.
      if (sync) begin
        cnt_d[i]   = '0;
        level_d[i] = 1'b0;
      end else if (wr_hit[i]) begin
        cnt_d[i] = '0;
      end else if (ch_en[i]) begin
        if (cnt_q[i] >= div_q[i]) begin
          cnt_d[i]   = '0;
          level_d[i] = ~level_q[i];
          tick_d[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= INIT_DIV[i*CNT_W +: CNT_W];
        cnt_q[i] <= '0;
      end
      level_q <= '0;
      tick_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      level_q <= level_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    rd_div = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rd_div[i*CNT_W +: CNT_W] = div_q[i];
    end
  end

  assign tick  = tick_q;
  assign level = level_q;

endmodule

// File: tb/tb_tick_gen.sv
// Directed plus randomized bench for tick_gen; a countdown reference model feeds an expected queue.
module tb_tick_gen;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int W      = NUM_CH*CNT_W + 2*NUM_CH;
  localparam logic [NUM_CH*CNT_W-1:0] INIT_DIV = {8'd4, 8'd1, 8'd0};

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_CH-1:0]       ch_en = '1;
  logic                    sync = 1'b0;
  logic                    wr_en = 1'b0;
  logic [3:0]              wr_ch = '0;
  logic [CNT_W-1:0]        wr_div = '0;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       level;
  logic [NUM_CH*CNT_W-1:0] rd_div;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  logic [CNT_W-1:0]  m_div [NUM_CH];
  int                m_rem [NUM_CH];
  logic [NUM_CH-1:0] m_lvl;
  logic [NUM_CH-1:0] m_tick;

  tick_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .INIT_DIV(INIT_DIV)) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .sync(sync), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_div(wr_div), .tick(tick), .level(level), .rd_div(rd_div)
  );

  always #5 clk = ~clk;

  // m_rem counts edges remaining until the next tick.
  task automatic model_step();
    logic [NUM_CH*CNT_W-1:0] init_v;
    logic hit;
    init_v = INIT_DIV;
    for (int i = 0; i < NUM_CH; i++) begin
      hit = wr_en && (int'(wr_ch) < NUM_CH) && (int'(wr_ch) == i);
      m_tick[i] = 1'b0;
      if (rst) begin
        m_div[i] = init_v[i*CNT_W +: CNT_W];
        m_rem[i] = int'(m_div[i]) + 1;
        m_lvl[i] = 1'b0;
      end else begin
        if (hit) m_div[i] = wr_div;
        if (sync || hit) begin
          m_rem[i] = int'(m_div[i]) + 1;
          if (sync) m_lvl[i] = 1'b0;
        end else if (ch_en[i]) begin
          if (m_rem[i] == 1) begin
            m_tick[i] = 1'b1;
            m_lvl[i]  = ~m_lvl[i];
            m_rem[i]  = int'(m_div[i]) + 1;
          end else begin
            m_rem[i] = m_rem[i] - 1;
          end
        end
      end
    end
  endtask

  task automatic cycle(input string tag);
    logic [NUM_CH*CNT_W-1:0] rd_e;
    logic [W-1:0] e;
    logic [W-1:0] o;
    model_step();
    for (int i = 0; i < NUM_CH; i++) rd_e[i*CNT_W +: CNT_W] = m_div[i];
    exp_q.push_back({rd_e, m_lvl, m_tick});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    o = {rd_div, level, tick};
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL sb_%s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (2) cycle("reset");
    chk("reset_tick", 32'(tick), 32'd0);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_rd_div", 32'(rd_div), 32'(INIT_DIV));
    rst = 1'b0;

    repeat (4) cycle("run");
    chk("first_tick2_early", 32'(tick[2]), 32'd0);
    cycle("run");
    chk("first_tick2", 32'(tick[2]), 32'd1);
    chk("first_level2", 32'(level[2]), 32'd1);
    repeat (2) cycle("run");

    ch_en = 3'b011;
    repeat (7) begin
      cycle("freeze");
      chk("freeze_tick2", 32'(tick[2]), 32'd0);
      chk("freeze_level2", 32'(level[2]), 32'd1);
    end
    ch_en = 3'b111;
    repeat (2) cycle("resume");
    chk("resume_tick2_early", 32'(tick[2]), 32'd0);
    cycle("resume");
    chk("resume_tick2", 32'(tick[2]), 32'd1);
    chk("resume_level2", 32'(level[2]), 32'd0);
    repeat (2) cycle("run");

    wr_en = 1'b1; wr_ch = 4'd2; wr_div = 8'd2;
    cycle("write");
    wr_en = 1'b0;
    chk("wr_rd_div", 32'(rd_div), 32'({8'd2, 8'd1, 8'd0}));
    chk("wr_level2", 32'(level[2]), 32'd0);
    repeat (2) cycle("post_wr");
    chk("wr_tick2_early", 32'(tick[2]), 32'd0);
    cycle("post_wr");
    chk("wr_tick2", 32'(tick[2]), 32'd1);
    repeat (6) cycle("post_wr");

    wr_en = 1'b1; wr_ch = 4'd5; wr_div = 8'd9;
    cycle("inv_wr");
    wr_en = 1'b0;
    chk("inv_rd_div", 32'(rd_div), 32'({8'd2, 8'd1, 8'd0}));
    repeat (6) cycle("post_inv");

    wr_en = 1'b1; wr_ch = 4'd2; wr_div = 8'd4;
    cycle("restore");
    wr_en = 1'b0;
    repeat (3) cycle("run");

    sync = 1'b1; wr_en = 1'b1; wr_ch = 4'd0; wr_div = 8'd3;
    cycle("sync_wr");
    sync = 1'b0; wr_en = 1'b0;
    chk("sync_level", 32'(level), 32'd0);
    chk("sync_rd_div", 32'(rd_div), 32'({8'd4, 8'd1, 8'd3}));
    repeat (3) cycle("post_sync");
    chk("sync_tick0_early", 32'(tick[0]), 32'd0);
    cycle("post_sync");
    chk("sync_tick0", 32'(tick[0]), 32'd1);
    chk("sync_tick2_early", 32'(tick[2]), 32'd0);
    cycle("post_sync");
    chk("sync_tick2", 32'(tick[2]), 32'd1);
    chk("sync_level2", 32'(level[2]), 32'd1);
    repeat (3) cycle("post_sync");

    rst = 1'b1;
    cycle("mid_rst");
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_rd_div", 32'(rd_div), 32'(INIT_DIV));
    rst = 1'b0;

    repeat (80) begin
      ch_en  = 3'($urandom_range(0, 7));
      sync   = ($urandom_range(0, 15) == 0);
      wr_en  = ($urandom_range(0, 5) == 0);
      wr_ch  = 4'($urandom_range(0, 5));
      wr_div = 8'($urandom_range(0, 5));
      cycle("rand");
    end
    ch_en = 3'b111; sync = 1'b0; wr_en = 1'b0;
    repeat (10) cycle("tail");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_gen.md
# tick_gen

Parametrised multi-channel clock-enable and square-wave generator that replaces the fixed three-output divider used by the parking meter timing path. Each of `NUM_CH` channels divides the system clock by a runtime-programmable divisor and produces both a one-cycle `tick` strobe and a 50% duty `level` output. Channels can be individually enabled, reprogrammed without reset, and phase-aligned together. Downstream logic (seconds countdown, display multiplex scan, blink) consumes the `tick` strobes as clock enables on `clk`; it does not use the `level` outputs as clocks.

## Interface
- `NUM_CH`, 3: number of channels (1..16).
- `CNT_W`, 32: counter and divisor width.
- `INIT_DIV`, {30000000, 20000, 50000000}: reset divisors, packed `NUM_CH*CNT_W` bits, channel 0 in LSBs; defaults give 1 Hz, fast scan and blink rates at 100 MHz.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `ch_en`  in  NUM_CH  per-channel run enable.
- `sync`  in  1  one-cycle strobe; restarts all channels in phase.
- `wr_en`  in  1  divisor write strobe.
- `wr_ch`  in  4  channel index for the write.
- `wr_div`  in  CNT_W  new divisor value.
- `tick`  out  NUM_CH  one-cycle strobe per channel per half-period.
- `level`  out  NUM_CH  square-wave output per channel.
- `rd_div`  out  NUM_CH*CNT_W  current divisor registers, packed like `INIT_DIV`.

## Operation
- Per-channel state: `div[i]`, `cnt[i]` (CNT_W bits), `level[i]`, `tick[i]`; all registered.
- Reset (`rst`=1 at a rising edge): `div[i]`=INIT_DIV slice, `cnt`=0, `level`=0, `tick`=0. Reset has the highest priority over every other input.
- Run, `ch_en[i]`=1, with no sync or write to channel i:
  - if `cnt[i]` >= `div[i]`: `cnt[i]`<=0, `level[i]`<=~`level[i]`, `tick[i]`<=1;
  - else: `cnt[i]`<=`cnt[i]`+1, `tick[i]`<=0.
- Half-period = `div`+1 cycles; `level` period = 2*(`div`+1) cycles; `div`=0 gives `tick` high every cycle and `level` toggling every cycle.
- Hold, `ch_en[i]`=0: `cnt[i]` and `level[i]` freeze, `tick[i]`<=0. Re-enabling resumes from the frozen count.
- Write, `wr_en`=1 with `wr_ch`<NUM_CH: `div[wr_ch]`<=`wr_div`, `cnt[wr_ch]`<=0, `tick[wr_ch]`<=0, and `level[wr_ch]` is held. The write takes effect whether or not the channel is enabled. If `wr_ch`>=NUM_CH, the write is ignored.
- Sync: all channels get `cnt`<=0, `level`<=0 and `tick`<=0; `div` is unchanged; this applies regardless of `ch_en`.
- Sync and write in the same cycle: both apply. The divisor is updated, and counters and levels are cleared per the sync rule.
- The `>=` comparison is mandatory, so that a counter above its divisor wraps on the next enabled cycle instead of running to 2^CNT_W.
- Counter arithmetic is unsigned and modulo 2^CNT_W. No overflow is reachable given the `>=` compare.

## Timing
- All outputs are registered, and no output has a combinational path from any input.
- After reset release with `ch_en[i]`=1 throughout, the first `tick[i]` and `level[i]` rise appear at the (`div[i]`+1)th rising edge after the last reset edge. Thereafter they recur every `div[i]`+1 edges.
- `tick[i]` is high for exactly one cycle and coincides with the cycle in which `level[i]` has just toggled.
- Write latency: `rd_div` shows the new value one cycle after `wr_en`. The first tick with the new divisor D comes D+1 edges after the write edge.
- Sync latency: the first post-sync tick on every enabled channel comes `div[i]`+1 edges after the sync edge, so channels with equal divisors tick in the same cycle.
- Reset asserted mid-period drops `level` and `tick` to 0 on that edge. No partial tick is emitted.

## Test plan
- Reset defaults: NUM_CH=3, INIT_DIV={4,1,0}, `ch_en`=3'b111, hold `rst` for 2 cycles -> `tick[0]` high every cycle; `tick[1]` every 2nd cycle; `tick[2]` first at edge 5, then every 5 cycles; `level[2]` period 10; `rd_div` equals INIT_DIV.
- Enable freeze: `ch_en[2]`=0 for 7 cycles starting with `cnt[2]`=2 -> no `tick[2]` and `level[2]` constant during the freeze; after re-enable, the next tick comes 3 edges later.
- Runtime write: mid-period, write `wr_ch`=2, `wr_div`=2 -> `rd_div` slice becomes 2 next cycle; `level[2]` is unchanged at the write; next tick 3 edges after the write, then every 3.
- Invalid channel: write `wr_ch`=5 -> `rd_div` unchanged; all tick patterns are undisturbed.
- Sync and write together: sync and a write of `wr_ch`=0, `wr_div`=3 in the same cycle -> all `level`=0; channel 0 ticks at +4 edges; channel 2 (div 4) ticks at +5 edges.
- Reset mid-operation: assert `rst` with `level[2]`=1 and `cnt[2]`=3 -> next cycle `level`=0, `tick`=0, divisors return to INIT_DIV.
